// File: rtl/hessian_out_packer.sv
// Sink-side packer for hessian_conv: rounds, shifts and saturates each kernel sample,
// gathers BEATS input beats into one PORT_BITS word per kernel and tags frame boundaries.
module hessian_out_packer #(
  parameter int ROI_SIZE            = 64,
  parameter int PORT_BITS           = 128,
  parameter int IN_WIDTH            = 29,
  parameter int OUT_PIX_WIDTH       = 16,
  parameter int SHIFT               = 8,
  parameter int KERNEL_NUM          = 3,
  parameter int PIXELS_IN_PER_CYCLE = 2
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic                                                          clk_en,
  input  logic signed [KERNEL_NUM-1:0][PIXELS_IN_PER_CYCLE-1:0][IN_WIDTH-1:0] data_in,
  input  logic                                                          in_vld,
  output logic                                                          in_ready,
  output logic        [KERNEL_NUM-1:0][PORT_BITS-1:0]                   data_out,
  output logic                                                          out_vld,
  input  logic                                                          out_ready,
  output logic                                                          out_last,
  output logic                                                          frame_done,
  output logic                                                          sat_flag
);

  localparam int LANES  = PORT_BITS / OUT_PIX_WIDTH;
  localparam int BEATS  = LANES / PIXELS_IN_PER_CYCLE;
  localparam int WORDS  = ROI_SIZE * ROI_SIZE / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ACC_W  = IN_WIDTH + 1;

  localparam logic signed [ACC_W-1:0] RND =
    (SHIFT > 0) ? (ACC_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << (OUT_PIX_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] PIX_MIN = ~PIX_MAX;

  // One guard bit above the input keeps the rounding add from wrapping.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [IN_WIDTH-1:0] x);
    logic signed [ACC_W-1:0] xe;
    xe = {x[IN_WIDTH-1], x};
    return (xe + RND) >>> SHIFT;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] y);
    return (y > PIX_MAX) || (y < PIX_MIN);
  endfunction

  function automatic logic [OUT_PIX_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] y);
    if (y > PIX_MAX)      return PIX_MAX[OUT_PIX_WIDTH-1:0];
    else if (y < PIX_MIN) return PIX_MIN[OUT_PIX_WIDTH-1:0];
    else                  return y[OUT_PIX_WIDTH-1:0];
  endfunction

  logic [BEAT_W-1:0]                   beat_cnt;
  logic [WORD_W-1:0]                   word_cnt;
  logic [KERNEL_NUM-1:0][PORT_BITS-1:0] acc_p0;
  logic [KERNEL_NUM-1:0][PORT_BITS-1:0] acc_nxt;
  logic [KERNEL_NUM-1:0][PORT_BITS-1:0] data_p1;
  logic                                vld_p1;
  logic                                beat_sat;
  logic                                last_beat;
  logic                                accept;
  logic                                complete;
  logic                                out_hs;
  logic                                frame_start;

  // Stage 0: scale the incoming beat into its lanes of the partial word.
  always_comb begin
    acc_nxt  = acc_p0;
    beat_sat = 1'b0;
    for (int k = 0; k < KERNEL_NUM; k++) begin
      for (int p = 0; p < PIXELS_IN_PER_CYCLE; p++) begin
        beat_sat = beat_sat | sat_hit(round_shift(data_in[k][p]));
        acc_nxt[k][(int'(beat_cnt) * PIXELS_IN_PER_CYCLE + p) * OUT_PIX_WIDTH +: OUT_PIX_WIDTH] =
          saturate(round_shift(data_in[k][p]));
      end
    end
  end

  assign last_beat   = (beat_cnt == BEAT_W'(BEATS - 1));
  assign in_ready    = clk_en && (!last_beat || !vld_p1 || out_ready);
  assign accept      = in_vld && in_ready;
  assign complete    = accept && last_beat;
  assign out_hs      = clk_en && vld_p1 && out_ready;
  assign frame_start = (word_cnt == '0) && (beat_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      word_cnt   <= '0;
      vld_p1     <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      sat_flag   <= 1'b0;
    end else if (clk_en) begin
      frame_done <= out_hs && out_last;
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        sat_flag <= beat_sat | (sat_flag & ~frame_start);
      end
      // A completing beat refills the output even while the old word hands off.
      if (complete) begin
        vld_p1   <= 1'b1;
        out_last <= (word_cnt == WORD_W'(WORDS - 1));
        word_cnt <= (word_cnt == WORD_W'(WORDS - 1)) ? '0 : word_cnt + 1'b1;
      end else if (out_hs) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Stage 1: partial-word accumulator and output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0  <= '0;
      data_p1 <= '0;
    end else if (clk_en) begin
      if (accept && !last_beat) acc_p0  <= acc_nxt;
      if (complete)             data_p1 <= acc_nxt;
    end
  end

  assign out_vld  = vld_p1;
  assign data_out = data_p1;

endmodule

// File: tb/tb_hessian_out_packer.sv
// Directed plus randomized bench for hessian_out_packer, checked cycle by cycle against
// a sample-count based reference model.
module tb_hessian_out_packer;

  localparam int ROI_SIZE = 64;
  localparam int PB       = 128;
  localparam int IW       = 29;
  localparam int OW       = 16;
  localparam int SHIFT    = 8;
  localparam int KN       = 3;
  localparam int PP       = 2;
  localparam int LANES    = PB / OW;
  localparam int BEATS    = LANES / PP;
  localparam int WORDS    = ROI_SIZE * ROI_SIZE / LANES;
  localparam int FRAME    = WORDS * BEATS;
  localparam int CW       = KN * PB;
  localparam longint PMAX = (longint'(1) << (OW - 1)) - 1;
  localparam longint PMIN = -(longint'(1) << (OW - 1));

  logic clk;
  logic rst_n;
  logic clk_en;
  logic signed [KN-1:0][PP-1:0][IW-1:0] data_in;
  logic in_vld;
  logic in_ready;
  logic [KN-1:0][PB-1:0] data_out;
  logic out_vld;
  logic out_ready;
  logic out_last;
  logic frame_done;
  logic sat_flag;

  hessian_out_packer #(
    .ROI_SIZE(ROI_SIZE), .PORT_BITS(PB), .IN_WIDTH(IW), .OUT_PIX_WIDTH(OW),
    .SHIFT(SHIFT), .KERNEL_NUM(KN), .PIXELS_IN_PER_CYCLE(PP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .data_in(data_in), .in_vld(in_vld),
    .in_ready(in_ready), .data_out(data_out), .out_vld(out_vld), .out_ready(out_ready),
    .out_last(out_last), .frame_done(frame_done), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: everything derives from the number of accepted beats.
  int                nacc;
  bit                mvld, mlast, msat, mfd;
  logic [KN-1:0][PB-1:0] mword;
  int                lanes [KN][LANES];
  longint            din [KN][PP];
  int                obs_words, obs_last, obs_fd;

  task automatic chk_v(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int scale(input longint x, output bit sat);
    longint d, v, q;
    if (SHIFT == 0) q = x;
    else begin
      d = longint'(1) << SHIFT;
      v = x + d / 2;
      q = v / d;
      if ((v % d != 0) && (v < 0)) q = q - 1;
    end
    sat = 1'b0;
    if (q > PMAX) begin q = PMAX; sat = 1'b1; end
    else if (q < PMIN) begin q = PMIN; sat = 1'b1; end
    return int'(q);
  endfunction

  task automatic model_reset();
    nacc = 0; mvld = 0; mlast = 0; msat = 0; mfd = 0; mword = '0;
    for (int k = 0; k < KN; k++) for (int l = 0; l < LANES; l++) lanes[k][l] = 0;
  endtask

  task automatic check_outputs();
    chk_b("out_vld", out_vld, mvld);
    if (mvld) begin
      chk_v("data_out", data_out, mword);
      chk_b("out_last", out_last, mlast);
    end
    chk_b("sat_flag", sat_flag, msat);
    chk_b("frame_done", frame_done, mfd);
  endtask

  task automatic rand_din(input int range);
    for (int k = 0; k < KN; k++)
      for (int p = 0; p < PP; p++)
        din[k][p] = longint'($urandom_range(0, 2 * range)) - longint'(range);
  endtask

  task automatic step(input bit v, input bit ordy, input bit en);
    bit pr, acc, hs, sat, fstart;
    int beat, word, y;
    in_vld = v; out_ready = ordy; clk_en = en;
    for (int k = 0; k < KN; k++) for (int p = 0; p < PP; p++) data_in[k][p] = IW'(din[k][p]);
    #1;
    check_outputs();
    pr = en && (((nacc % BEATS) != BEATS - 1) || !mvld || ordy);
    chk_b("in_ready", in_ready, pr);
    acc = v && pr;
    hs  = en && mvld && ordy;
    if (hs && out_vld === 1'b1) begin
      obs_words++;
      if (out_last === 1'b1) obs_last++;
    end
    if (frame_done === 1'b1) obs_fd++;
    @(posedge clk);
    #1;
    if (en) begin
      fstart = (nacc % FRAME) == 0;
      mfd = hs && mlast;
      if (hs) mvld = 0;
      if (acc) begin
        beat = nacc % BEATS;
        word = (nacc / BEATS) % WORDS;
        if (fstart) msat = 0;
        for (int k = 0; k < KN; k++)
          for (int p = 0; p < PP; p++) begin
            y = scale(din[k][p], sat);
            lanes[k][beat * PP + p] = y;
            if (sat) msat = 1;
          end
        nacc++;
        if (beat == BEATS - 1) begin
          mvld  = 1;
          mlast = (word == WORDS - 1);
          for (int k = 0; k < KN; k++)
            for (int l = 0; l < LANES; l++) mword[k][l * OW +: OW] = OW'(lanes[k][l]);
        end
      end
    end
  endtask

  task automatic run_until(input int target, input int range, input bit en_rand, input bit rdy_rand);
    int guard, prev;
    bit v, r, e;
    guard = 0;
    rand_din(range);
    while (nacc < target && guard < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      r = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      e = en_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
      prev = nacc;
      step(v, r, e);
      if (nacc != prev) rand_din(range);
      guard++;
    end
    chk_v("run_reached", CW'(nacc), CW'(target));
  endtask

  logic [PB-1:0] exp_w;
  int prev_n, g;

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; in_vld = 1'b0; out_ready = 1'b0; data_in = '0;
    model_reset();
    obs_words = 0; obs_last = 0; obs_fd = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk_v("reset_data", data_out, '0);
    chk_b("reset_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;

    // Ramp pattern: lane n carries n after rounding.
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < KN; k++) for (int p = 0; p < PP; p++) din[k][p] = 'h100 * (b * PP + p);
      step(1, 1, 1);
      if (b == BEATS - 2) chk_b("ramp_latency", out_vld, 1'b0);
    end
    chk_b("ramp_vld", out_vld, 1'b1);
    chk_v("ramp_word", CW'(data_out[0]), CW'(128'h0007_0006_0005_0004_0003_0002_0001_0000));
    chk_b("ramp_nosat", sat_flag, 1'b0);

    // Full-scale inputs clamp to the output range.
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < KN; k++) begin
        din[k][0] = (longint'(1) << 28) - 1;
        din[k][1] = -(longint'(1) << 28);
      end
      step(1, 1, 1);
    end
    exp_w = {4{32'h8000_7FFF}};
    chk_v("sat_word", CW'(data_out[1]), CW'(exp_w));
    chk_b("sat_set", sat_flag, 1'b1);

    // Round-half-up around zero.
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < KN; k++) for (int p = 0; p < PP; p++) din[k][p] = 0;
      if (b == 0) for (int k = 0; k < KN; k++) begin din[k][0] = 128;  din[k][1] = 127;  end
      if (b == 1) for (int k = 0; k < KN; k++) begin din[k][0] = -128; din[k][1] = -129; end
      step(1, 1, 1);
    end
    chk_v("round_lanes", CW'(data_out[2][63:0]), CW'(64'hFFFF_0000_0000_0001));

    // Global enable low: nothing moves.
    rand_din(1 << 20);
    repeat (3) step(1, 1, 0);
    chk_b("en_low_hold", out_vld, 1'b1);

    // Backpressure: one more word, then stall downstream with input pending.
    for (int b = 0; b < BEATS; b++) begin rand_din(1 << 20); step(1, 1, 1); end
    rand_din(1 << 20);
    for (int i = 0; i < 10; i++) begin
      prev_n = nacc;
      step(1, 0, 1);
      if (nacc != prev_n) rand_din(1 << 20);
    end
    chk_b("bp_stalled", in_ready, 1'b0);
    step(1, 1, 1);
    chk_b("bp_no_bubble", out_vld, 1'b1);

    // Finish frame 0 with random traffic, then a clean first beat clears sat_flag.
    run_until(FRAME, 1 << 25, 1, 1);
    rand_din(1 << 20);
    g = 0;
    while (nacc == FRAME && g < 100) begin step(1, 1, 1); g++; end
    chk_b("sat_cleared", sat_flag, 1'b0);

    // Reset in the middle of word 5 of frame 1.
    run_until(FRAME + 5 * BEATS + 3, 1 << 20, 1, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk_v("midrst_data", data_out, '0);
    chk_b("midrst_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_words = 0; obs_last = 0; obs_fd = 0;

    // One complete frame with random valid/ready.
    run_until(FRAME, 1 << 22, 0, 1);
    g = 0;
    while (mvld && g < 100) begin step(0, 1, 1); g++; end
    step(0, 1, 1);
    step(0, 1, 1);
    chk_v("frame_words", CW'(obs_words), CW'(WORDS));
    chk_v("frame_lasts", CW'(obs_last), CW'(1));
    chk_v("frame_done_pulses", CW'(obs_fd), CW'(1));

    // Word counter wrapped: the next word is not a frame end.
    for (int b = 0; b < BEATS; b++) begin rand_din(1 << 20); step(1, 1, 1); end
    chk_b("wrap_vld", out_vld, 1'b1);
    chk_b("wrap_last", out_last, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hessian_out_packer.md
Name: hessian_out_packer

Overview:
- Sink-side partner of hessian_conv. Consumes the per-kernel pixel-pair stream, scales and saturates each full-width result, and packs it into PORT_BITS-wide words (one word per kernel) for the memory write port.
- Applies backpressure to the conv datapath through in_ready, which upstream uses to gate its clk_en.
- Marks the last word of each ROI frame.

Parameters:
- ROI_SIZE, 64: ROI edge length; frame = ROI_SIZE*ROI_SIZE pixels per kernel.
- PORT_BITS, 128: output word width per kernel.
- IN_WIDTH, 29: signed input sample width (8+16+clog2(25)).
- OUT_PIX_WIDTH, 16: signed packed pixel width.
- SHIFT, 8: arithmetic right-shift applied before saturation (0 to 27 allowed).
- KERNEL_NUM, 3: number of kernel channels.
- PIXELS_IN_PER_CYCLE, 2: samples per kernel per input beat.
- Derived:
  - LANES = PORT_BITS/OUT_PIX_WIDTH = 8.
  - BEATS = LANES/PIXELS_IN_PER_CYCLE = 4.
  - WORDS = ROI_SIZE*ROI_SIZE/LANES = 512.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- clk_en, input, 1: global enable; when 0, all state holds.
- data_in, input, [KERNEL_NUM][PIXELS_IN_PER_CYCLE][IN_WIDTH] signed: conv results.
- in_vld, input, 1: data_in valid.
- in_ready, output, 1: beat accepted when in_vld && in_ready && clk_en.
- data_out, output, [KERNEL_NUM][PORT_BITS]: packed words.
- out_vld, output, 1: data_out valid.
- out_ready, input, 1: downstream accepts the word.
- out_last, output, 1: qualifies the final word of a frame.
- frame_done, output, 1: one-cycle pulse when the last word handshakes.
- sat_flag, output, 1: sticky flag; a sample in the current frame saturated.

Behaviour:
- Reset values (async): out_vld, out_last, frame_done, sat_flag = 0; data_out = 0; beat_cnt = 0; word_cnt = 0; accumulator = 0.
- Scaling, per sample x:
  - If SHIFT > 0, y = (x + 2^(SHIFT-1)) >>> SHIFT, computed at IN_WIDTH+1 bits so it cannot overflow. If SHIFT = 0, y = x.
  - Clamp y to [-2^(OUT_PIX_WIDTH-1), 2^(OUT_PIX_WIDTH-1)-1]. A clamp on any accepted sample sets sat_flag.
- Lane mapping: sample p of beat b goes to lane L = b*PIXELS_IN_PER_CYCLE + p, bits [(L+1)*OUT_PIX_WIDTH-1 -: OUT_PIX_WIDTH] of data_out[k]. This is the same little-end order the input packer uses.
- Beat accumulation:
  - beat_cnt counts 0..BEATS-1.
  - Beats 0..BEATS-2 write into the accumulator lanes.
  - The beat at BEATS-1 is merged with the accumulator straight into the output register (out_vld := 1), and beat_cnt wraps to 0.
- in_ready = clk_en && ((beat_cnt != BEATS-1) || !out_vld || out_ready). This is combinational from out_ready; a full word and a new completion may swap in the same cycle.
- Latency: out_vld rises on the clock edge that accepts the final beat of a word. The word is visible the cycle after that beat is presented.
- Output hold: while out_vld && !out_ready, data_out and out_last stay stable. out_vld drops only on handshake with no simultaneous completion.
- Simultaneous handshake and completion: the new word loads and out_vld stays 1. No bubble and no loss.
- Frame tracking:
  - word_cnt increments on each word load into the output register; out_last = 1 when the loaded word has index WORDS-1.
  - word_cnt wraps to 0 after WORDS-1.
  - frame_done pulses in the cycle after the out_last handshake.
- sat_flag clears on acceptance of the first beat of a frame (word_cnt == 0, beat_cnt == 0). That beat's own saturation still sets it.
- clk_en = 0: no counter, register or flag changes; in_ready = 0; out_vld and data_out hold. Downstream handshakes are ignored while clk_en = 0.
- in_vld without in_ready: the beat is not consumed, and upstream must hold it.
- Reset mid-frame: the partial word is discarded, counters return to 0, and the next accepted beat is lane 0 of word 0.

Test Plan:
- SHIFT=8, all samples 0x100*n for n = beat*2+p, out_ready=1 → data_out[k] lanes = 0,1,...,7 (word 0x0007_0006_..._0000); out_vld one cycle after beat 3; no sat_flag.
- Inputs +2^28-1 and -2^28, SHIFT=8 → lanes 0x7FFF and 0x8000; sat_flag = 1. Then feed a full frame with no saturation → sat_flag = 0 after the first beat.
- Rounding with SHIFT=8: x = 0x80 → 1; x = 0x7F → 0; x = -0x80 → 0; x = -0x81 → -1.
- out_ready = 0 for 10 cycles after word 0 → in_ready = 0 only at beat_cnt = 3; data_out is stable. Release out_ready with in_vld high → word 0 handshake and word 1 load in the same cycle, no gap.
- 2048 beats with random in_vld/out_ready → exactly 512 words; out_last only on word 511; single frame_done pulse; word_cnt = 0 afterwards.
- Assert rst_n low after beat 2 of word 5 → outputs return to reset values immediately. Next beat lands in lane 0 and word_cnt restarts, so out_last appears after 512 new words.
